// File: rtl/rhs_proc_pkg.sv
// Shared types, constants and helpers for the RHS2000 frame spike detector.
package rhs_proc_pkg;

  localparam int MAX_STREAMS = 32;
  localparam int IDX_W       = 5;

  localparam logic [63:0] MAGIC_DEF   = 64'h8d542c8a49712f0b;
  localparam logic [15:0] OFFSET_ZERO = 16'h8000;

  typedef enum logic [1:0] {HUNT, TS0, TS1, DATA} state_t;

  // Number of enabled streams in a mask.
  function automatic logic [IDX_W:0] popcount(input logic [MAX_STREAMS-1:0] m);
    logic [IDX_W:0] n;
    n = '0;
    for (int i = 0; i < MAX_STREAMS; i++) n = n + {{IDX_W{1'b0}}, m[i]};
    return n;
  endfunction

  // Lowest enabled index strictly above idx; wraps to the lowest enabled index.
  function automatic logic [IDX_W-1:0] next_enabled(input logic [MAX_STREAMS-1:0] mask,
                                                    input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = MAX_STREAMS-1; i >= 0; i--)
      if (mask[i]) r = IDX_W'(i);
    for (int i = MAX_STREAMS-1; i >= 0; i--)
      if (mask[i] && i > int'(idx)) r = IDX_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/spike_refractory_unit.sv
// Per-stream hit accumulator, refractory counter and trigger gating.
module spike_refractory_unit #(
  parameter int REFRACT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 smp_hit,
  input  logic                 fend,
  input  logic [REFRACT_W-1:0] refract,
  output logic                 trig
);

  logic                 hit_q;
  logic                 hit_f;
  logic [REFRACT_W-1:0] rcnt;

  // Include a hit on the final sample, which arrives together with fend.
  assign hit_f = hit_q | smp_hit;

  // Accumulate hits over a frame; at frame end fire or count down refractory.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_q <= 1'b0;
      rcnt  <= '0;
      trig  <= 1'b0;
    end else begin
      trig <= 1'b0;
      if (clr)          hit_q <= 1'b0;
      else if (smp_hit) hit_q <= 1'b1;
      if (fend && en) begin
        if (hit_f && rcnt == '0) begin
          trig <= 1'b1;
          rcnt <= refract;
        end else if (rcnt != '0) begin
          rcnt <= rcnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rhs_frame_spike_detector.sv
// Locks onto RHS2000 frame headers, demuxes samples per stream and raises
// per-stream spike triggers with a frame-counted refractory period.
module rhs_frame_spike_detector
  import rhs_proc_pkg::*;
#(
  parameter int          NUM_STREAMS = 8,
  parameter int          CHANNELS    = 16,
  parameter int          DATA_W      = 16,
  parameter logic [63:0] MAGIC       = MAGIC_DEF,
  parameter int          REFRACT_W   = 8,
  parameter int          ERR_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [NUM_STREAMS-1:0] data_stream_en,
  input  logic [DATA_W-1:0]      thresh,
  input  logic                   mode,
  input  logic [REFRACT_W-1:0]   refract,
  output logic [NUM_STREAMS-1:0] trig_stim,
  output logic                   frame_done,
  output logic [31:0]            timestamp,
  output logic                   locked,
  output logic [ERR_W-1:0]       sync_err
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t                 state_q, state_d;
  logic [1:0]             hdr_q, hdr_d;
  logic [IDX_W-1:0]       sptr_q, sptr_d, nxt;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [NUM_STREAMS-1:0] mask_q;
  logic [DATA_W-1:0]      thresh_q;
  logic                   mode_q;
  logic [REFRACT_W-1:0]   refract_q;
  logic [31:0]            ts_sh;
  logic [MAX_STREAMS-1:0] mask_ext;
  logic                   hdr_done, fend, err_inc, raw_hit, smp_ok;
  logic signed [DATA_W:0] v, t, av;

  // Widen the latched mask for the package helpers.
  always_comb begin
    mask_ext = '0;
    mask_ext[NUM_STREAMS-1:0] = mask_q;
  end

  // Offset-binary to signed, 17-bit compare so |min| cannot overflow.
  always_comb begin
    v       = {in_data[DATA_W-1] ^ 1'b1, in_data ^ DATA_W'(OFFSET_ZERO)};
    t       = {1'b0, thresh_q};
    av      = v[DATA_W] ? -v : v;
    raw_hit = mode_q ? (av >= t) : (v <= -t);
    smp_ok  = in_valid && (state_q == DATA) && raw_hit;
  end

  // Header hunt and frame walk: next state and frame events.
  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    sptr_d   = sptr_q;
    ch_d     = ch_q;
    hdr_done = 1'b0;
    fend     = 1'b0;
    err_inc  = 1'b0;
    nxt      = next_enabled(mask_ext, sptr_q);
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_data == MAGIC[hdr_q*DATA_W +: DATA_W]) begin
            if (hdr_q == 2'd3) begin
              hdr_done = 1'b1;
              hdr_d    = 2'd0;
              state_d  = TS0;
            end else begin
              hdr_d = hdr_q + 2'd1;
            end
          end else begin
            err_inc = (hdr_q != 2'd0);
            hdr_d   = (in_data == MAGIC[DATA_W-1:0]) ? 2'd1 : 2'd0;
          end
        end
        TS0: state_d = TS1;
        TS1: begin
          if (popcount(mask_ext) == '0) begin
            fend    = 1'b1;
            state_d = HUNT;
          end else begin
            sptr_d  = next_enabled(mask_ext, '1);
            ch_d    = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          sptr_d = nxt;
          // Wrapping back to the lowest enabled stream closes a channel row.
          if (nxt <= sptr_q) begin
            ch_d = ch_q + 1'b1;
            if (ch_q == CH_W'(CHANNELS-1)) begin
              fend    = 1'b1;
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State, latched config, timestamp shadow and frame status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= HUNT;
      hdr_q      <= 2'd0;
      sptr_q     <= '0;
      ch_q       <= '0;
      mask_q     <= '0;
      thresh_q   <= '0;
      mode_q     <= 1'b0;
      refract_q  <= '0;
      ts_sh      <= '0;
      timestamp  <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      sptr_q     <= sptr_d;
      ch_q       <= ch_d;
      frame_done <= fend;
      if (hdr_done) begin
        mask_q    <= data_stream_en;
        thresh_q  <= thresh;
        mode_q    <= mode;
        refract_q <= refract;
      end
      if (in_valid && state_q == TS0) ts_sh[15:0]  <= in_data[15:0];
      if (in_valid && state_q == TS1) ts_sh[31:16] <= in_data[15:0];
      // An empty frame ends on TS_HI itself, before the shadow holds it.
      if (fend) timestamp <= (state_q == TS1) ? {in_data[15:0], ts_sh[15:0]} : ts_sh;
      if (hdr_done)  locked <= 1'b1;
      else if (fend) locked <= 1'b0;
      if (err_inc && sync_err != '1) sync_err <= sync_err + 1'b1;
    end
  end

  for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_lane
    logic hit_s;
    assign hit_s = smp_ok && (sptr_q == IDX_W'(s));
    spike_refractory_unit #(.REFRACT_W(REFRACT_W)) u_sru (
      .clk     (clk),
      .reset   (reset),
      .en      (mask_q[s]),
      .clr     (hdr_done),
      .smp_hit (hit_s),
      .fend    (fend),
      .refract (refract_q),
      .trig    (trig_stim[s])
    );
  end

endmodule

// File: tb/tb_rhs_frame_spike_detector.sv
// Randomized frame stimulus checked against a frame-level reference model.
module tb_rhs_frame_spike_detector;

  localparam int NS = 8;
  localparam int CH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data = '0;
  logic [NS-1:0] data_stream_en = '0;
  logic [15:0]   thresh = '0;
  logic          mode = 1'b0;
  logic [7:0]    refract = '0;
  logic [NS-1:0] trig_stim;
  logic          frame_done;
  logic [31:0]   timestamp;
  logic          locked;
  logic [7:0]    sync_err;

  rhs_frame_spike_detector dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .data_stream_en(data_stream_en), .thresh(thresh), .mode(mode), .refract(refract),
    .trig_stim(trig_stim), .frame_done(frame_done), .timestamp(timestamp),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  int          fd_cnt = 0, exp_fd = 0, stray = 0, exp_serr = 0;
  int          rc [NS];
  logic [15:0] smp [NS][CH];
  logic [63:0] mg = 64'h8d542c8a49712f0b;

  // Frame_done pulses and any trigger outside a frame_done cycle.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (trig_stim != '0 && !frame_done) stray++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic word(input logic [15:0] w, input int gap);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic quiet();
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < CH; c++)
        smp[s][c] = 16'(32768 + int'($urandom_range(0, 60)) - 30);
  endtask

  // Frame-level reference: hit if any sample crosses, then refractory rules.
  task automatic model(input logic [NS-1:0] m, input logic [15:0] th, input logic md,
                       input logic [7:0] rf, output logic [NS-1:0] et);
    et = '0;
    for (int s = 0; s < NS; s++) begin
      bit h;
      h = 0;
      if (!m[s]) continue;
      for (int c = 0; c < CH; c++) begin
        int v;
        v = int'(smp[s][c]) - 32768;
        if (md) h |= (((v < 0) ? -v : v) >= int'(th));
        else    h |= (v <= -int'(th));
      end
      if (h && rc[s] == 0) begin
        et[s] = 1'b1;
        rc[s] = int'(rf);
      end else if (rc[s] > 0) begin
        rc[s]--;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) rc[s] = 0;
    exp_serr = 0;
    chk({tag, "_trig"}, trig_stim, '0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_ts"}, timestamp, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_serr"}, sync_err, 0);
    reset = 1'b1;
  endtask

  task automatic frame(input string tag, input logic [NS-1:0] m, input logic [15:0] th,
                       input logic md, input logic [7:0] rf, input int gmax, input int abort_at);
    logic [31:0]   ts;
    logic [NS-1:0] et;
    int            k;
    ts = $urandom;
    data_stream_en = m; thresh = th; mode = md; refract = rf;
    for (int i = 0; i < 4; i++) word(mg[i*16 +: 16], 0);
    // Mid-frame config changes must not matter until the next header.
    data_stream_en = NS'($urandom); thresh = 16'($urandom); mode = 1'($urandom);
    refract = 8'($urandom);
    word(ts[15:0], $urandom_range(0, gmax));
    word(ts[31:16], $urandom_range(0, gmax));
    if (m != '0) chk({tag, "_locked_in"}, locked, 1);
    k = 0;
    for (int c = 0; c < CH; c++)
      for (int s = 0; s < NS; s++)
        if (m[s]) begin
          if (k == abort_at) begin
            do_reset({tag, "_rst"});
            return;
          end
          word(smp[s][c], $urandom_range(0, gmax));
          k++;
        end
    model(m, th, md, rf, et);
    exp_fd++;
    chk({tag, "_fd"}, frame_done, 1);
    chk({tag, "_trig"}, trig_stim, et);
    chk({tag, "_ts"}, timestamp, ts);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_serr"}, sync_err, exp_serr);
  endtask

  initial begin
    for (int s = 0; s < NS; s++) rc[s] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trig", trig_stim, '0);
    chk("rst_fd", frame_done, 0);
    chk("rst_ts", timestamp, 0);
    chk("rst_locked", locked, 0);
    chk("rst_serr", sync_err, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single stream, negative spike on ch5.
    quiet(); smp[0][5] = 16'h8000 - 16'd150;
    frame("neg", 8'h01, 16'd100, 1'b0, 8'd0, 0, -1);

    // Refractory of 2 frames over 4 spiking frames.
    for (int f = 0; f < 4; f++) begin
      quiet(); smp[0][3] = 16'h8000 - 16'd500;
      frame("refr", 8'h01, 16'd100, 1'b0, 8'd2, 1, -1);
    end

    // Corrupt third header word, then a good frame.
    word(mg[15:0], 0); word(mg[31:16], 0); word(16'h1234, 0);
    exp_serr++;
    quiet(); smp[0][9] = 16'h8000 - 16'd300;
    frame("resync", 8'h01, 16'd100, 1'b0, 8'd0, 0, -1);

    // Two streams, positive spike on stream 7 ch15, absolute mode.
    quiet(); smp[7][15] = 16'h8000 + 16'd200;
    frame("abs", 8'h82, 16'd150, 1'b1, 8'd0, 0, -1);

    // Empty mask ends at TS_HI.
    quiet();
    frame("empty", 8'h00, 16'd10, 1'b0, 8'd0, 0, -1);

    // Boundaries: |-32768| vs thresh 0x8000, thresh 0 both modes.
    quiet(); smp[2][0] = 16'h0000;
    frame("minabs", 8'h04, 16'h8000, 1'b1, 8'd0, 0, -1);
    for (int c = 0; c < CH; c++) smp[3][c] = 16'h8001;
    smp[3][7] = 16'h8000;
    frame("th0neg", 8'h08, 16'd0, 1'b0, 8'd0, 0, -1);
    frame("th0abs", 8'h10, 16'd0, 1'b1, 8'd0, 0, -1);

    // Reset mid-DATA, then a normal frame.
    quiet(); smp[0][0] = 16'h0000;
    frame("abort", 8'h01, 16'd100, 1'b0, 8'd3, 0, 5);
    @(posedge clk); #1;
    quiet(); smp[0][2] = 16'h0000;
    frame("after", 8'h01, 16'd100, 1'b0, 8'd3, 0, -1);

    // Randomized frames, back-to-back and with gaps.
    for (int f = 0; f < 40; f++) begin
      logic [15:0] th;
      quiet();
      for (int s = 0; s < NS; s++)
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, 39) == 0) smp[s][c] = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       th = 16'd0;
        1:       th = 16'($urandom_range(0, 400));
        default: th = 16'($urandom);
      endcase
      frame("rnd", NS'($urandom), th, 1'($urandom), 8'($urandom_range(0, 3)),
            $urandom_range(0, 2), -1);
    end

    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fd_count", fd_cnt, exp_fd);
    chk("stray_trig", stray, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
